bcd_score_renderer: RTL and testbench

//  Parametrised N-digit decimal score counter and on-screen renderer for the Dino VGA path.
//  - Counts in packed BCD, so no divide or modulo logic is needed.
//  - Latches the displayed value once per frame, so digits never tear mid-frame.
//  - Generates glyph-ROM addresses directly from the pixel x/y, with no per-sprite offset counters.
//  - Drives a 1-bit pixel_on into the VGA colour mux. Runs in the 25 MHz pixel-clock domain.

---
 rtl/bcd_score_renderer.sv | 177 +++++++++++++++++
 tb/tb_bcd_score_renderer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_score_renderer.sv
// bcd_score_renderer: packed-BCD score counter with a frame-latched display
// copy and a glyph-ROM address generator for the on-screen score digits.
// The counter saturates at all-9s and sets a sticky overflow flag.
// Optional feature macro: HISCORE_EN adds a high-score register that is
// updated on the rising edge of freeze. Without it, hi_bcd is tied to 0.
// Pixel stream has no backpressure: x/y/active are taken every cycle.
// glyph_addr is valid 1 cycle later, and pixel_on is valid 2 cycles later.
module bcd_score_renderer #(
  parameter int DIGITS   = 5,
  parameter int GLYPH_W  = 14,
  parameter int GLYPH_H  = 14,
  parameter int GAP      = 2,
  parameter int ORIGIN_X = 545,
  parameter int ORIGIN_Y = 10,
  parameter int ROM_AW   = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  freeze,
  input  logic                  clear,
  input  logic                  frame_start,
  input  logic                  active,
  input  logic [9:0]            x,
  input  logic [8:0]            y,
  output logic [ROM_AW-1:0]     glyph_addr,
  input  logic                  glyph_data,
  output logic                  pixel_on,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   hi_bcd
);

  localparam int W     = 4 * DIGITS;
  localparam int PITCH = GLYPH_W + GAP;
  localparam logic [ROM_AW-1:0] GLYPH_SZ = ROM_AW'(GLYPH_W * GLYPH_H);
  localparam logic [ROM_AW-1:0] GW_A     = ROM_AW'(GLYPH_W);
  localparam logic [10:0]       OY       = 11'(ORIGIN_Y);
  localparam logic [10:0]       GW11     = 11'(GLYPH_W);
  localparam logic [10:0]       GH11     = 11'(GLYPH_H);

  logic [W-1:0]      disp;
  logic [W-1:0]      score_inc;
  logic              all_nines;
  logic              carry;
  logic [10:0]       x11;
  logic [10:0]       y11;
  logic [10:0]       lo;
  logic [10:0]       row;
  logic [10:0]       col;
  logic [3:0]        val;
  logic              y_in;
  logic              in_win;
  logic [ROM_AW-1:0] addr_next;
  logic              win_d1;
  logic              win_d2;

  // Ripple the +1 through all nibbles in one cycle; flag the all-9s state.
  always_comb begin
    score_inc = score_bcd;
    carry     = 1'b1;
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (score_bcd[4*i +: 4] != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (score_bcd[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_bcd[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Score counter: clear beats freeze, freeze beats tick; saturate at all-9s.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_bcd <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      score_bcd <= '0;
      overflow  <= 1'b0;
    end else if (tick && !freeze && !overflow) begin
      if (all_nines) overflow  <= 1'b1;
      else           score_bcd <= score_inc;
    end
  end

  // Display copy only changes at frame start so digits never tear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            disp <= '0;
    else if (frame_start) disp <= score_bcd;
  end

  // Find which digit cell (if any) the pixel falls in and its glyph offset.
  always_comb begin
    x11    = {1'b0, x};
    y11    = {2'b0, y};
    y_in   = (y11 >= OY) && (y11 < OY + GH11);
    row    = y11 - OY;
    in_win = 1'b0;
    val    = 4'd0;
    col    = 11'd0;
    lo     = 11'd0;
    for (int k = 0; k < DIGITS; k++) begin
      lo = 11'(ORIGIN_X + k * PITCH);
      if (y_in && (x11 >= lo) && (x11 < lo + GW11)) begin
        in_win = 1'b1;
        val    = disp[4*(DIGITS-1-k) +: 4];
        col    = x11 - lo;
      end
    end
    addr_next = ROM_AW'(val) * GLYPH_SZ + ROM_AW'(row) * GW_A + ROM_AW'(col);
  end

  // Two-stage pixel pipeline aligned with the synchronous glyph ROM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glyph_addr <= '0;
      win_d1     <= 1'b0;
      win_d2     <= 1'b0;
    end else begin
      if (in_win) glyph_addr <= addr_next;
      win_d1 <= in_win & active;
      win_d2 <= win_d1;
    end
  end

  assign pixel_on = win_d2 & glyph_data;

`ifdef HISCORE_EN
  logic         freeze_d;
  logic         score_gt;
  logic         decided;
  logic [W-1:0] hi_q;

  // Nibble-wise magnitude compare, most significant digit first.
  always_comb begin
    score_gt = 1'b0;
    decided  = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (!decided && (score_bcd[4*i +: 4] != hi_q[4*i +: 4])) begin
        decided  = 1'b1;
        score_gt = score_bcd[4*i +: 4] > hi_q[4*i +: 4];
      end
    end
  end

  // Capture a new high score when freeze (game over) rises; clear leaves it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freeze_d <= 1'b0;
      hi_q     <= '0;
    end else begin
      freeze_d <= freeze;
      if (freeze && !freeze_d && score_gt) hi_q <= score_bcd;
    end
  end

  assign hi_bcd = hi_q;
`else
  assign hi_bcd = '0;
`endif

  function automatic logic bcd_legal(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  a_bcd_legal: assert property (@(posedge clk) disable iff (reset) bcd_legal(score_bcd));

endmodule

// File: tb/tb_bcd_score_renderer.sv
// Testbench for bcd_score_renderer: directed vectors, expected values pushed
// into queues by the stimulus, popped and compared by negedge monitors.
module tb_bcd_score_renderer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #20 clk = ~clk;

  logic        tick, freeze, clear, frame_start, active;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [11:0] glyph_addr;
  logic        glyph_data;
  logic        pixel_on;
  logic [19:0] score_bcd;
  logic        overflow;
  logic [19:0] hi_bcd;

  // Second, 2-digit instance used to reach saturation quickly.
  logic        tick2, clear2;
  logic        freeze2 = 1'b0;
  logic        glyph_data2 = 1'b0;
  logic [11:0] glyph_addr2;
  logic        pixel_on2;
  logic [7:0]  score2;
  logic        overflow2;
  logic [7:0]  hi2;

  bcd_score_renderer dut (
    .clk(clk), .reset(reset), .tick(tick), .freeze(freeze), .clear(clear),
    .frame_start(frame_start), .active(active), .x(x), .y(y),
    .glyph_addr(glyph_addr), .glyph_data(glyph_data), .pixel_on(pixel_on),
    .score_bcd(score_bcd), .overflow(overflow), .hi_bcd(hi_bcd)
  );

  bcd_score_renderer #(.DIGITS(2)) dut2 (
    .clk(clk), .reset(reset), .tick(tick2), .freeze(freeze2), .clear(clear2),
    .frame_start(frame_start), .active(active), .x(x), .y(y),
    .glyph_addr(glyph_addr2), .glyph_data(glyph_data2), .pixel_on(pixel_on2),
    .score_bcd(score2), .overflow(overflow2), .hi_bcd(hi2)
  );

  // Glyph ROM model: one-cycle synchronous read of a fixed bit pattern.
  function automatic logic rom_bit(input logic [11:0] a);
    return ~a[1];
  endfunction

  always @(posedge clk) glyph_data <= rom_bit(glyph_addr);

`ifdef HISCORE_EN
  localparam logic [19:0] HI_EXP = 20'h00300;
`else
  localparam logic [19:0] HI_EXP = 20'h00000;
`endif

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  // State channel entries: {sel[3:0], value[19:0]}.
  logic [23:0] exp_q[$];
  string       name_q[$];
  logic        st_probe = 1'b0;

  // Pixel channel entries: {chk_addr, win, addr[11:0]}.
  logic [13:0] pexp_q[$];
  string       pname_q[$];
  logic [13:0] p2_q[$];
  string       p2name_q[$];
  logic        pix_probe = 1'b0;
  logic        v1 = 1'b0;
  logic        v2 = 1'b0;

  task automatic cmp(input string nm, input logic [19:0] act, input logic [19:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // State monitor: compares the selected DUT output when a probe is raised.
  always @(negedge clk) begin
    if (st_probe) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL state_queue_empty: got 0 entries expected >=1");
      end else begin
        logic [23:0] e;
        logic [19:0] act;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        case (e[23:20])
          4'd0:    act = score_bcd;
          4'd1:    act = {19'd0, overflow};
          4'd2:    act = {12'd0, score2};
          4'd3:    act = {19'd0, overflow2};
          4'd4:    act = hi_bcd;
          4'd5:    act = {19'd0, pixel_on};
          default: act = {8'd0, glyph_addr};
        endcase
        cmp(nm, act, e[19:0]);
      end
    end
  end

  always @(posedge clk) begin
    v1 <= pix_probe;
    v2 <= v1;
  end

  // Pixel monitor: glyph_addr one cycle after issue, pixel_on two cycles after.
  always @(negedge clk) begin
    if (v2) begin
      if (p2_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL pixel_queue_empty: got 0 entries expected >=1");
      end else begin
        logic [13:0] e;
        string nm;
        e  = p2_q.pop_front();
        nm = p2name_q.pop_front();
        cmp({nm, "_pixel_on"}, {19'd0, pixel_on}, {19'd0, e[12] & rom_bit(e[11:0])});
      end
    end
    if (v1) begin
      if (pexp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL addr_queue_empty: got 0 entries expected >=1");
      end else begin
        logic [13:0] e;
        string nm;
        e  = pexp_q.pop_front();
        nm = pname_q.pop_front();
        if (e[13]) cmp({nm, "_addr"}, {8'd0, glyph_addr}, {8'd0, e[11:0]});
        p2_q.push_back(e);
        p2name_q.push_back(nm);
      end
    end
  end

  // ---------------- driver tasks (called just after a rising edge) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) @(posedge clk);
    #1 tick = 1'b0;
  endtask

  task automatic ticks2(input int n);
    tick2 = 1'b1;
    repeat (n) @(posedge clk);
    #1 tick2 = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1; step(); frame_start = 1'b0;
  endtask

  task automatic check_state(input string nm, input logic [3:0] sel, input logic [19:0] v);
    exp_q.push_back({sel, v});
    name_q.push_back(nm);
    st_probe = 1'b1;
    step();
    st_probe = 1'b0;
  endtask

  task automatic pix(input string nm, input logic [9:0] xx, input logic [8:0] yy,
                     input logic act, input logic chk, input logic win,
                     input logic [11:0] addr);
    x = xx; y = yy; active = act;
    pexp_q.push_back({chk, win, addr});
    pname_q.push_back(nm);
    pix_probe = 1'b1;
    step();
    pix_probe = 1'b0;
  endtask

  task automatic drain();
    repeat (3) step();
  endtask

  // Watchdog: the run is cycle-bounded, this only guards against a stall.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; tick = 1'b0; freeze = 1'b0; clear = 1'b0; frame_start = 1'b0;
    active = 1'b0; x = 10'd0; y = 9'd0; tick2 = 1'b0; clear2 = 1'b0;
    repeat (3) step();
    check_state("rst_pixel_on_in_reset", 4'd5, 20'h0);
    reset = 1'b0;
    check_state("rst_score", 4'd0, 20'h0);
    check_state("rst_overflow", 4'd1, 20'h0);
    check_state("rst_hi", 4'd4, 20'h0);
    check_state("rst_glyph_addr", 4'd6, 20'h0);
    check_state("rst_score2", 4'd2, 20'h0);

    // High score: captured on freeze rise; a lower later score leaves it.
    ticks(300);
    freeze = 1'b1; step(); step();
    check_state("hi_after_300", 4'd4, HI_EXP);
    freeze = 1'b0; step();
    pulse_clear();
    ticks(120);
    freeze = 1'b1; step(); step();
    check_state("hi_after_120", 4'd4, HI_EXP);
    check_state("score_120", 4'd0, 20'h00120);
    freeze = 1'b0;
    pulse_clear();
    check_state("clear_keeps_hi", 4'd4, HI_EXP);

    // 1234 ticks, latch and render every digit of the display copy.
    ticks(1234);
    pulse_frame();
    check_state("score_1234", 4'd0, 20'h01234);
    check_state("ovf_1234", 4'd1, 20'h0);
    pix("d0_last_row_col", 10'd558, 9'd23, 1'b1, 1'b1, 1'b1, 12'd195);
    pix("d1_val1",         10'd563, 9'd13, 1'b1, 1'b1, 1'b1, 12'd240);
    pix("d3_val3",         10'd593, 9'd10, 1'b1, 1'b1, 1'b1, 12'd588);
    pix("d4_val4_col13",   10'd622, 9'd10, 1'b1, 1'b1, 1'b1, 12'd797);
    pix("gap_first_col",   10'd559, 9'd10, 1'b1, 1'b1, 1'b0, 12'd797);
    pix("left_of_origin",  10'd544, 9'd10, 1'b1, 1'b1, 1'b0, 12'd797);
    pix("below_glyph",     10'd558, 9'd24, 1'b1, 1'b1, 1'b0, 12'd797);
    pix("above_glyph",     10'd563, 9'd9,  1'b1, 1'b1, 1'b0, 12'd797);
    pix("right_of_last",   10'd623, 9'd10, 1'b1, 1'b1, 1'b0, 12'd797);
    pix("inactive",        10'd563, 9'd13, 1'b0, 1'b0, 1'b0, 12'd0);
    drain();

    // Freeze blocks ticks; clear wins over a coincident tick.
    freeze = 1'b1;
    ticks(100);
    freeze = 1'b0;
    check_state("freeze_holds", 4'd0, 20'h01234);
    clear = 1'b1; tick = 1'b1; step(); clear = 1'b0; tick = 1'b0;
    check_state("clear_beats_tick", 4'd0, 20'h0);

    // Saturation on the 2-digit instance.
    clear2 = 1'b1; step(); clear2 = 1'b0;
    ticks2(98);
    check_state("s2_98", 4'd2, 20'h98);
    ticks2(1);
    check_state("s2_99", 4'd2, 20'h99);
    check_state("s2_ovf_0", 4'd3, 20'h0);
    ticks2(1);
    check_state("s2_sat", 4'd2, 20'h99);
    check_state("s2_ovf_1", 4'd3, 20'h1);
    ticks2(1);
    check_state("s2_hold", 4'd2, 20'h99);
    check_state("s2_ovf_sticky", 4'd3, 20'h1);
    clear2 = 1'b1; step(); clear2 = 1'b0;
    check_state("s2_clear", 4'd2, 20'h0);
    check_state("s2_clear_ovf", 4'd3, 20'h0);

    // Display 00007: address arithmetic and gap column.
    pulse_clear();
    ticks(7);
    pulse_frame();
    pix("d4_val7",     10'd612, 9'd15, 1'b1, 1'b1, 1'b1, 12'd1445);
    pix("d4_val7_c4",  10'd613, 9'd15, 1'b1, 1'b1, 1'b1, 12'd1446);
    pix("gap_col",     10'd559, 9'd15, 1'b1, 1'b1, 1'b0, 12'd1446);
    pix("msd_origin",  10'd545, 9'd10, 1'b1, 1'b1, 1'b1, 12'd0);
    drain();

    // Tick coincident with frame_start: display takes the pre-increment value.
    pulse_clear();
    ticks(41);
    tick = 1'b1; frame_start = 1'b1; step(); tick = 1'b0; frame_start = 1'b0;
    check_state("score_42", 4'd0, 20'h00042);
    pix("disp41_lsd", 10'd609, 9'd10, 1'b1, 1'b1, 1'b1, 12'd196);
    pix("disp41_d3",  10'd593, 9'd10, 1'b1, 1'b1, 1'b1, 12'd784);
    pulse_frame();
    pix("disp42_lsd", 10'd609, 9'd10, 1'b1, 1'b1, 1'b1, 12'd392);
    pix("disp42_d3",  10'd593, 9'd10, 1'b1, 1'b1, 1'b1, 12'd784);
    drain();

    // Reset mid-frame with the pixel held inside a lit glyph cell.
    x = 10'd609; y = 9'd10; active = 1'b1;
    repeat (3) step();
    check_state("lit_before_reset", 4'd5, 20'h1);
    reset = 1'b1;
    #1;
    check_state("reset_drops_pixel", 4'd5, 20'h0);
    check_state("reset_score", 4'd0, 20'h0);
    check_state("reset_hi", 4'd4, 20'h0);
    reset = 1'b0;
    check_state("first_cycle_after_reset", 4'd5, 20'h0);
    pix("post_reset_pixel", 10'd609, 9'd10, 1'b1, 1'b1, 1'b1, 12'd0);
    drain();

    if (exp_q.size() != 0 || pexp_q.size() != 0 || p2_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL queues_not_empty: got %0d entries expected 0",
               exp_q.size() + pexp_q.size() + p2_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
